// File: rtl/quadrature_decoder_if.sv
// Bundle of quadrature inputs and decoded position outputs for quadrature_decoder.
// There is no valid/ready handshake: A/B are free-running levels, and the outputs are registered levels/pulses.
interface quadrature_decoder_if #(
    parameter int WIDTH = 8
);
    logic             A;
    logic             B;
    logic             clr;
    logic [WIDTH-1:0] count;     // two's-complement position
    logic             step_cw;
    logic             step_ccw;
    logic             dir;
    logic             error;
    logic [1:0]       q_state;   // accepted {A,B} state, exposed for observation

    modport master (
        output A, B, clr,
        input  count, step_cw, step_ccw, dir, error, q_state
    );

    modport slave (
        input  A, B, clr,
        output count, step_cw, step_ccw, dir, error, q_state
    );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes A/B, debounces them over FILTER cycles,
// and turns accepted Gray-code transitions into step pulses and a wrapping position count.
module quadrature_decoder #(
    parameter int WIDTH  = 8,
    parameter int FILTER = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    quadrature_decoder_if.slave qd
);

    localparam logic [3:0]       FILTER_CNT = 4'(FILTER);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_CW,
        MOVE_CCW,
        MOVE_BAD
    } move_t;

    logic [1:0]       sync1, sync2;
    logic [1:0]       q, cand;
    logic [3:0]       stab_cnt;
    logic [3:0]       run_len;
    logic             accept;
    move_t            move;
    logic [WIDTH-1:0] count_r;
    logic             step_cw_r, step_ccw_r, dir_r, error_r;

    // run_len is how many consecutive edges (including this one) sync2 has held a non-Q value.
    always_comb begin
        run_len = 4'd1;
        if (stab_cnt != 4'd0 && sync2 == cand)
            run_len = stab_cnt + 4'd1;
        accept = (sync2 != q) && (run_len >= FILTER_CNT);

        move = MOVE_NONE;
        case ({q, sync2})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: move = MOVE_CW;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: move = MOVE_CCW;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: move = MOVE_BAD;
            default:                            move = MOVE_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 2'b00;
            sync2      <= 2'b00;
            q          <= 2'b00;
            cand       <= 2'b00;
            stab_cnt   <= 4'd0;
            count_r    <= '0;
            step_cw_r  <= 1'b0;
            step_ccw_r <= 1'b0;
            dir_r      <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            sync1      <= {qd.A, qd.B};
            sync2      <= sync1;
            step_cw_r  <= 1'b0;
            step_ccw_r <= 1'b0;

            if (sync2 == q) begin
                stab_cnt <= 4'd0;
            end else if (accept) begin
                q        <= sync2;
                stab_cnt <= 4'd0;
            end else begin
                stab_cnt <= run_len;
                cand     <= sync2;
            end

            if (accept) begin
                case (move)
                    MOVE_CW: begin
                        step_cw_r <= 1'b1;
                        dir_r     <= 1'b0;
                        count_r   <= count_r + ONE;
                    end
                    MOVE_CCW: begin
                        step_ccw_r <= 1'b1;
                        dir_r      <= 1'b1;
                        count_r    <= count_r - ONE;
                    end
                    MOVE_BAD: error_r <= 1'b1;
                    default: ;
                endcase
            end

            // Clear wins over a same-edge accept for count/error; pulses and dir still follow the accept.
            if (qd.clr) begin
                count_r <= '0;
                error_r <= 1'b0;
            end
        end
    end

    assign qd.count    = count_r;
    assign qd.step_cw  = step_cw_r;
    assign qd.step_ccw = step_ccw_r;
    assign qd.dir      = dir_r;
    assign qd.error    = error_r;
    assign qd.q_state  = q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed scenarios plus randomized A/B traffic,
// checked every cycle against a phase-arithmetic reference model.
module tb_quadrature_decoder;

    localparam int WIDTH  = 8;
    localparam int FILTER = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quadrature_decoder_if #(.WIDTH(WIDTH)) qd ();

    quadrature_decoder #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .qd    (qd)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cw_seen      = 0;
    int ccw_seen     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Positions along the clockwise cycle 00 -> 10 -> 11 -> 01.
    logic [1:0]       in_hist[$];
    logic [1:0]       m_q;
    logic [WIDTH-1:0] m_count;
    logic             m_cw, m_ccw, m_dir, m_err;

    function automatic int phase(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] past_in(input int back);
        if (back >= in_hist.size()) return 2'b00;
        return in_hist[in_hist.size() - 1 - back];
    endfunction

    task automatic model_reset();
        in_hist.delete();
        m_q = 2'b00; m_count = '0;
        m_cw = 1'b0; m_ccw = 1'b0; m_dir = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] ab, input logic clr_v);
        logic [1:0] s;
        bit         stable;
        int         d;
        in_hist.push_back(ab);
        if (in_hist.size() > 40) void'(in_hist.pop_front());
        s = past_in(2);
        stable = 1'b1;
        for (int j = 1; j < FILTER; j++)
            if (past_in(2 + j) != s) stable = 1'b0;
        m_cw = 1'b0; m_ccw = 1'b0;
        if (stable && s != m_q) begin
            d = (phase(s) - phase(m_q) + 4) % 4;
            if (d == 1) begin m_cw = 1'b1; m_dir = 1'b0; m_count = m_count + 1'b1; end
            else if (d == 3) begin m_ccw = 1'b1; m_dir = 1'b1; m_count = m_count - 1'b1; end
            else m_err = 1'b1;
            m_q = s;
        end
        if (clr_v) begin m_count = '0; m_err = 1'b0; end
    endtask

    task automatic check_outputs();
        check_eq("count",     32'(qd.count),    32'(m_count));
        check_eq("step_cw",   32'(qd.step_cw),  32'(m_cw));
        check_eq("step_ccw",  32'(qd.step_ccw), 32'(m_ccw));
        check_eq("dir",       32'(qd.dir),      32'(m_dir));
        check_eq("error",     32'(qd.error),    32'(m_err));
        check_eq("q_state",   32'(qd.q_state),  32'(m_q));
        check_eq("exclusive", 32'(qd.step_cw & qd.step_ccw), 32'd0);
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic tick(input logic [1:0] ab, input logic clr_v);
        qd.A = ab[1]; qd.B = ab[0]; qd.clr = clr_v;
        @(posedge clk);
        if (rst_n) model_edge(ab, clr_v);
        else       model_reset();
        @(negedge clk);
        check_outputs();
        cw_seen  += int'(qd.step_cw);
        ccw_seen += int'(qd.step_ccw);
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        for (int i = 0; i < n; i++) tick(ab, 1'b0);
    endtask

    // Assert reset between edges, check it takes effect without a clock, toggle A/B while held.
    task automatic reset_pulse(input int cycles);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_async_count", 32'(qd.count), 32'd0);
        check_eq("rst_async_error", 32'(qd.error), 32'd0);
        check_eq("rst_async_q",     32'(qd.q_state), 32'd0);
        for (int i = 0; i < cycles; i++) tick((i % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
        rst_n = 1'b1;
    endtask

    logic [1:0] gray[4];
    int         p;
    logic [1:0] cur_ab;
    int         r;
    int         len;

    initial begin
        gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
        qd.A = 1'b0; qd.B = 1'b0; qd.clr = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();

        // Reset held with A/B toggling, then 20 quiet cycles at 00.
        for (int i = 0; i < 6; i++) tick((i % 2 == 0) ? 2'b11 : 2'b10, 1'b0);
        rst_n = 1'b1;
        cw_seen = 0; ccw_seen = 0;
        hold(2'b00, 20);
        check_eq("idle_pulses", 32'(cw_seen + ccw_seen), 32'd0);

        // Clockwise cycle with first-pulse latency check.
        for (int i = 1; i <= 6; i++) begin
            tick(2'b10, 1'b0);
            check_eq("cw_latency", 32'(qd.step_cw), 32'(i == 4));
        end
        hold(2'b11, 6); hold(2'b01, 6); hold(2'b00, 6);
        check_eq("cw_pulses", 32'(cw_seen), 32'd4);
        check_eq("cw_count",  32'(qd.count), 32'h04);
        check_eq("cw_dir",    32'(qd.dir), 32'd0);

        // Counter-clockwise cycle from a cleared count.
        tick(2'b00, 1'b1);
        cw_seen = 0; ccw_seen = 0;
        hold(2'b01, 6); hold(2'b11, 6); hold(2'b10, 6); hold(2'b00, 6);
        check_eq("ccw_pulses", 32'(ccw_seen), 32'd4);
        check_eq("ccw_count",  32'(qd.count), 32'hFC);
        check_eq("ccw_dir",    32'(qd.dir), 32'd1);

        // Illegal jump, then clear.
        cw_seen = 0; ccw_seen = 0;
        hold(2'b11, 6);
        check_eq("bad_error",  32'(qd.error), 32'd1);
        check_eq("bad_count",  32'(qd.count), 32'hFC);
        check_eq("bad_pulses", 32'(cw_seen + ccw_seen), 32'd0);
        tick(2'b11, 1'b1);
        check_eq("clr_error", 32'(qd.error), 32'd0);
        check_eq("clr_count", 32'(qd.count), 32'h00);
        reset_pulse(3);

        // One-cycle glitch on A must be filtered out.
        cw_seen = 0; ccw_seen = 0;
        tick(2'b10, 1'b0);
        hold(2'b00, 6);
        check_eq("glitch_pulses", 32'(cw_seen + ccw_seen), 32'd0);
        check_eq("glitch_q",      32'(qd.q_state), 32'd0);
        check_eq("glitch_count",  32'(qd.count), 32'd0);

        // Walk to 0x7F, step across the signed boundary, then reset asynchronously.
        p = 0;
        for (int i = 0; i < 127; i++) begin
            p = (p + 1) % 4;
            hold(gray[p], 3);
        end
        hold(gray[p], 3);
        check_eq("wrap_7f", 32'(qd.count), 32'h7F);
        p = (p + 1) % 4;
        hold(gray[p], 6);
        check_eq("wrap_80", 32'(qd.count), 32'h80);
        reset_pulse(2);
        check_eq("wrap_reset_count", 32'(qd.count), 32'd0);

        // Randomized traffic: legal steps either way, illegal jumps, glitches, clears, resets.
        cur_ab = 2'b00;
        hold(2'b00, 4);
        for (int seg = 0; seg < 400; seg++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3)      cur_ab = gray[(phase(cur_ab) + 1) % 4];
            else if (r <= 7) cur_ab = gray[(phase(cur_ab) + 3) % 4];
            else if (r == 8) cur_ab = cur_ab ^ 2'b11;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++)
                tick(cur_ab, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 39) == 0) reset_pulse(int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter: WIDTH, default 8, width of the position counter in bits.
REQ-002 Parameter: FILTER, default 2, range 1..15, number of consecutive cycles a new A/B value must hold before it is accepted.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: A  input  1  quadrature phase A, asynchronous to clk.
REQ-006 Port: B  input  1  quadrature phase B, asynchronous to clk.
REQ-007 Port: clr  input  1  synchronous clear of count and error.
REQ-008 Port: count  output  WIDTH  signed two's-complement position.
REQ-009 Port: step_cw  output  1  one-cycle pulse per accepted clockwise step.
REQ-010 Port: step_ccw  output  1  one-cycle pulse per accepted counter-clockwise step.
REQ-011 Port: dir  output  1  direction of last accepted step: 0 = clockwise, 1 = counter-clockwise.
REQ-012 Port: error  output  1  sticky flag for an illegal transition.

Function
REQ-013 A and B shall each pass through a two-flop synchronizer; the second-stage pair {A,B} is the sampled value S.
REQ-014 The block shall hold an accepted state Q (2 bits) and a stability counter.
REQ-015 Filter: when S != Q and S has equalled the same value for FILTER consecutive rising edges, Q <= S on that edge (the accept edge).
REQ-016 Any change of S before FILTER edges restarts the stability count; a pulse on S shorter than FILTER cycles shall cause no change to Q or to any output.
REQ-017 Latency: an A/B change held stable yields the accept edge at the (FILTER+2)th rising edge after the change; step/error outputs are updated on that edge.
REQ-018 Clockwise transitions (Q_old->Q_new, as {A,B}): 00->10, 10->11, 11->01, 01->00.
REQ-019 Counter-clockwise transitions: 00->01, 01->11, 11->10, 10->00.
REQ-020 Clockwise accept: step_cw = 1 for exactly one cycle, count + 1, dir = 0.
REQ-021 Counter-clockwise accept: step_ccw = 1 for exactly one cycle, count - 1, dir = 1.
REQ-022 Illegal accept (00<->11, 10<->01): error = 1 (sticky), no step pulse, count and dir unchanged, Q still updates to S.
REQ-023 step_cw and step_ccw shall never be high in the same cycle; with a stable S, no pulses shall occur.
REQ-024 Count arithmetic is modulo 2^WIDTH: 0x7F + 1 -> 0x80; 0x00 - 1 -> 0xFF (WIDTH = 8).
REQ-025 clr = 1 sets count = 0 and error = 0 on that edge, with priority over a simultaneous accept.
REQ-026 Step pulses and dir still follow REQ-020/021 on a clr edge; clr does not affect Q, the synchronizers or the filter.

Reset
REQ-027 rst_n low shall immediately set count = 0, step_cw = 0, step_ccw = 0, dir = 0, error = 0, Q = 00, synchronizers = 00, and stability counter = 0, independent of clk.
REQ-028 Reset asserted mid-sequence shall discard any partially filtered value.
REQ-029 After rst_n deasserts, A/B = 00 shall produce no pulse.
REQ-030 After rst_n deasserts, A/B != 00 is treated as a normal transition from 00.

Verification
REQ-031 Reset: rst_n low with A/B toggling every cycle -> all outputs 0 throughout; after release with A/B = 00 -> no pulses for 20 cycles.
REQ-032 Clockwise sequence (FILTER = 2), each value held 6 cycles, 00->10->11->01->00 -> four step_cw pulses; count = 4; dir = 0; first pulse on the 4th rising edge after A rises.
REQ-033 Counter-clockwise sequence from count 0, 00->01->11->10->00 -> four step_ccw pulses; count = 0xFC; dir = 1.
REQ-034 Illegal transition: A/B 00->11 held 6 cycles -> error = 1, count unchanged, no pulses; then clr for 1 cycle -> error = 0, count = 0.
REQ-035 Glitch: A high for 1 cycle with FILTER = 2 -> no pulse, count unchanged, Q stays 00.
REQ-036 Wrap and mid-operation reset: 127 clockwise steps -> count = 0x7F; one more step -> 0x80; then async rst_n pulse between clk edges -> count = 0 immediately.
